// File: rtl/id_pipe_stage_pkg.sv
// Shared MIPS decode constants for the ID stage: opcodes, functs, ALU op/select codes,
// plus the combinational instruction decoder used by id_pipe_stage.
package id_pipe_stage_pkg;

    localparam logic [5:0] EXE_SPECIAL = 6'b000000;
    localparam logic [5:0] EXE_ANDI    = 6'b001100;
    localparam logic [5:0] EXE_ORI     = 6'b001101;
    localparam logic [5:0] EXE_XORI    = 6'b001110;
    localparam logic [5:0] EXE_LUI     = 6'b001111;
    localparam logic [5:0] EXE_LW      = 6'b100011;

    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_XOR = 6'b100110;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;

    localparam logic [7:0] EXE_NOP_OP = 8'b00000000;
    localparam logic [7:0] EXE_AND_OP = 8'b00100100;
    localparam logic [7:0] EXE_OR_OP  = 8'b00100101;
    localparam logic [7:0] EXE_XOR_OP = 8'b00100110;
    localparam logic [7:0] EXE_NOR_OP = 8'b00100111;
    localparam logic [7:0] EXE_LUI_OP = 8'b01011100;
    localparam logic [7:0] EXE_LW_OP  = 8'b11100011;

    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_LOAD  = 3'b111;

    localparam logic [31:0] ZeroWord   = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr = 5'b00000;

    typedef struct packed {
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic        re1;
        logic        re2;
        logic [31:0] imm;
        logic [4:0]  wd;
        logic        wreg;
        logic        invalid;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] inst);
        dec_t d;
        d         = '0;
        d.aluop   = EXE_NOP_OP;
        d.alusel  = EXE_RES_NOP;
        d.wd      = NOPRegAddr;
        d.invalid = 1'b1;
        case (inst[31:26])
            EXE_ORI, EXE_ANDI, EXE_XORI: begin
                d.re1     = 1'b1;
                d.imm     = {16'h0000, inst[15:0]};
                d.wd      = inst[20:16];
                d.wreg    = 1'b1;
                d.alusel  = EXE_RES_LOGIC;
                d.invalid = 1'b0;
                d.aluop   = (inst[31:26] == EXE_ORI)  ? EXE_OR_OP  :
                            (inst[31:26] == EXE_ANDI) ? EXE_AND_OP : EXE_XOR_OP;
            end
            EXE_LUI: begin
                d.imm     = {inst[15:0], 16'h0000};
                d.wd      = inst[20:16];
                d.wreg    = 1'b1;
                d.alusel  = EXE_RES_LOGIC;
                d.aluop   = EXE_LUI_OP;
                d.invalid = 1'b0;
            end
            EXE_LW: begin
                d.re1     = 1'b1;
                d.imm     = {{16{inst[15]}}, inst[15:0]};
                d.wd      = inst[20:16];
                d.wreg    = 1'b1;
                d.alusel  = EXE_RES_LOAD;
                d.aluop   = EXE_LW_OP;
                d.invalid = 1'b0;
            end
            EXE_SPECIAL: begin
                if (inst[5:2] == 4'b1001) begin
                    // rd=0 still writes; the regfile drops writes to $0
                    d.re1     = 1'b1;
                    d.re2     = 1'b1;
                    d.wd      = inst[15:11];
                    d.wreg    = 1'b1;
                    d.alusel  = EXE_RES_LOGIC;
                    d.invalid = 1'b0;
                    case (inst[5:0])
                        FUNCT_AND: d.aluop = EXE_AND_OP;
                        FUNCT_OR:  d.aluop = EXE_OR_OP;
                        FUNCT_XOR: d.aluop = EXE_XOR_OP;
                        default:   d.aluop = EXE_NOR_OP;
                    endcase
                end
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/id_pipe_stage_if.sv
// ID/EX pipeline register bus: payload plus valid/ready handshake toward EX.
interface id_pipe_stage_if #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3
);
    logic                ex_valid_o;
    logic                ex_ready_i;
    logic [ALUOP_W-1:0]  aluop_o;
    logic [ALUSEL_W-1:0] alusel_o;
    logic [DATA_W-1:0]   reg1_o;
    logic [DATA_W-1:0]   reg2_o;
    logic [REG_AW-1:0]   wd_o;
    logic                wreg_o;
    logic [DATA_W-1:0]   pc_o;
    logic                inst_invalid_o;

    modport master (
        output ex_valid_o, aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, pc_o, inst_invalid_o,
        input  ex_ready_i
    );
    modport slave (
        input  ex_valid_o, aluop_o, alusel_o, reg1_o, reg2_o, wd_o, wreg_o, pc_o, inst_invalid_o,
        output ex_ready_i
    );
endinterface

// File: rtl/id_operand_mux.sv
// One regfile read port: forwarding select (EX over MEM) and load-use hazard compare.
module id_operand_mux #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int FWD_EN = 1
) (
    input  logic              re,
    input  logic [REG_AW-1:0] addr,
    input  logic [DATA_W-1:0] rdata,
    input  logic [DATA_W-1:0] fallback,
    input  logic              ex_wreg,
    input  logic [REG_AW-1:0] ex_wd,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic              ex_is_load,
    input  logic              mem_wreg,
    input  logic [REG_AW-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] operand,
    output logic              hazard
);
    localparam bit FWD = (FWD_EN != 0);

    logic ex_hit, mem_hit, live;

    assign live    = re && (addr != '0);
    assign ex_hit  = ex_wreg && (ex_wd == addr);
    assign mem_hit = mem_wreg && (mem_wd == addr);

    always_comb begin
        operand = fallback;
        if (re) begin
            if (addr == '0)          operand = '0;
            else if (FWD && ex_hit)  operand = ex_wdata;
            else if (FWD && mem_hit) operand = mem_wdata;
            else                     operand = rdata;
        end
    end

    // Without forwarding every in-flight writer of this register must drain first
    assign hazard = live && ((ex_is_load && ex_hit) || (!FWD && (ex_hit || mem_hit)));

endmodule

// File: rtl/id_pipe_stage.sv
// Registered MIPS instruction-decode stage driving the ID/EX register with
// valid/ready handshake, flush, EX/MEM forwarding and load-use stall.
module id_pipe_stage
    import id_pipe_stage_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3,
    parameter int FWD_EN   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [31:0]       inst_i,
    output logic              id_ready_o,
    input  logic              flush_i,
    output logic              reg1_read_o,
    output logic              reg2_read_o,
    output logic [REG_AW-1:0] reg1_addr_o,
    output logic [REG_AW-1:0] reg2_addr_o,
    input  logic [DATA_W-1:0] reg1_data_i,
    input  logic [DATA_W-1:0] reg2_data_i,
    input  logic              ex_wreg_i,
    input  logic [REG_AW-1:0] ex_wd_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              ex_is_load_i,
    input  logic              mem_wreg_i,
    input  logic [REG_AW-1:0] mem_wd_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    id_pipe_stage_if.master   idex
);
    dec_t dec;
    logic [1:0]             re_v, hz_v;
    logic [1:0][REG_AW-1:0] addr_v;
    logic [1:0][DATA_W-1:0] rdata_v, fb_v, op_v;
    logic                   hazard, advance, load;

    assign dec         = decode(inst_i);
    assign re_v        = {dec.re2, dec.re1};
    assign addr_v[0]   = REG_AW'(inst_i[25:21]);
    assign addr_v[1]   = REG_AW'(inst_i[20:16]);
    assign rdata_v     = {reg2_data_i, reg1_data_i};
    assign fb_v[0]     = '0;
    assign fb_v[1]     = DATA_W'(dec.imm);

    assign reg1_read_o = dec.re1;
    assign reg2_read_o = dec.re2;
    assign reg1_addr_o = addr_v[0];
    assign reg2_addr_o = addr_v[1];

    for (genvar p = 0; p < 2; p++) begin : g_port
        id_operand_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_mux (
            .re        (re_v[p]),
            .addr      (addr_v[p]),
            .rdata     (rdata_v[p]),
            .fallback  (fb_v[p]),
            .ex_wreg   (ex_wreg_i),
            .ex_wd     (ex_wd_i),
            .ex_wdata  (ex_wdata_i),
            .ex_is_load(ex_is_load_i),
            .mem_wreg  (mem_wreg_i),
            .mem_wd    (mem_wd_i),
            .mem_wdata (mem_wdata_i),
            .operand   (op_v[p]),
            .hazard    (hz_v[p])
        );
    end

    assign hazard     = |hz_v;
    assign advance    = ~idex.ex_valid_o | idex.ex_ready_i;
    assign load       = advance & if_valid_i & ~hazard & ~flush_i;
    // Flush drops whatever is presented, so upstream may always hand it over
    assign id_ready_o = ~rst & (flush_i | (advance & ~hazard));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idex.ex_valid_o     <= 1'b0;
            idex.aluop_o        <= '0;
            idex.alusel_o       <= '0;
            idex.reg1_o         <= '0;
            idex.reg2_o         <= '0;
            idex.wd_o           <= '0;
            idex.wreg_o         <= 1'b0;
            idex.pc_o           <= '0;
            idex.inst_invalid_o <= 1'b0;
        end else if (flush_i) begin
            idex.ex_valid_o <= 1'b0;
        end else if (advance) begin
            idex.ex_valid_o <= load;
            if (load) begin
                idex.aluop_o        <= ALUOP_W'(dec.aluop);
                idex.alusel_o       <= ALUSEL_W'(dec.alusel);
                idex.reg1_o         <= op_v[0];
                idex.reg2_o         <= op_v[1];
                idex.wd_o           <= REG_AW'(dec.wd);
                idex.wreg_o         <= dec.wreg;
                idex.pc_o           <= pc_i;
                idex.inst_invalid_o <= dec.invalid;
            end
        end
    end

endmodule

// File: tb/tb_id_pipe_stage.sv
// Directed + randomized check of id_pipe_stage against a mnemonic-level reference model.
module tb_id_pipe_stage;

    typedef enum int {M_ORI, M_ANDI, M_XORI, M_LUI, M_AND, M_OR, M_XOR, M_NOR, M_LW, M_BAD} mn_t;

    typedef struct {
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        bit          uses_rs;
        bit          uses_rt;
        logic [31:0] imm_val;
        logic [4:0]  dest;
        bit          wr;
        bit          bad;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, if_valid, flush, ex_wreg, ex_is_load, mem_wreg;
    logic [31:0] pc, inst, ex_wdata, mem_wdata;
    logic [4:0]  ex_wd, mem_wd;
    logic        id_ready, r1_rd, r2_rd;
    logic [4:0]  r1_addr, r2_addr;
    logic [31:0] r1_data, r2_data;
    logic [31:0] rf [32];

    int checks = 0;
    int errors = 0;

    mn_t         cur_mn;
    logic [4:0]  cur_rs, cur_rt, cur_rd;
    logic [15:0] cur_imm;

    bit          e_valid, e_wreg, e_bad;
    logic [7:0]  e_aluop;
    logic [2:0]  e_alusel;
    logic [31:0] e_r1, e_r2, e_pc;
    logic [4:0]  e_wd;

    always #5 clk = ~clk;

    id_pipe_stage_if bus ();

    assign r1_data = rf[r1_addr];
    assign r2_data = rf[r2_addr];

    id_pipe_stage dut (
        .clk(clk), .rst(rst), .if_valid_i(if_valid), .pc_i(pc), .inst_i(inst),
        .id_ready_o(id_ready), .flush_i(flush),
        .reg1_read_o(r1_rd), .reg2_read_o(r2_rd),
        .reg1_addr_o(r1_addr), .reg2_addr_o(r2_addr),
        .reg1_data_i(r1_data), .reg2_data_i(r2_data),
        .ex_wreg_i(ex_wreg), .ex_wd_i(ex_wd), .ex_wdata_i(ex_wdata), .ex_is_load_i(ex_is_load),
        .mem_wreg_i(mem_wreg), .mem_wd_i(mem_wd), .mem_wdata_i(mem_wdata),
        .idex(bus.master)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t expect_of(mn_t mn, logic [4:0] rt, logic [4:0] rd, logic [15:0] imm);
        exp_t e;
        e = '{aluop: 8'h00, alusel: 3'd0, uses_rs: 0, uses_rt: 0, imm_val: 32'h0, dest: 5'd0, wr: 0, bad: 0};
        case (mn)
            M_ORI, M_ANDI, M_XORI: begin
                e.aluop = (mn == M_ORI) ? 8'h25 : (mn == M_ANDI) ? 8'h24 : 8'h26;
                e.alusel = 3'd1; e.uses_rs = 1; e.imm_val = 32'(imm); e.dest = rt; e.wr = 1;
            end
            M_LUI: begin
                e.aluop = 8'h5C; e.alusel = 3'd1; e.imm_val = 32'(imm) * 32'h1_0000; e.dest = rt; e.wr = 1;
            end
            M_LW: begin
                e.aluop = 8'hE3; e.alusel = 3'd7; e.uses_rs = 1;
                e.imm_val = 32'($signed(imm)); e.dest = rt; e.wr = 1;
            end
            M_AND, M_OR, M_XOR, M_NOR: begin
                e.aluop = (mn == M_AND) ? 8'h24 : (mn == M_OR) ? 8'h25 : (mn == M_XOR) ? 8'h26 : 8'h27;
                e.alusel = 3'd1; e.uses_rs = 1; e.uses_rt = 1; e.dest = rd; e.wr = 1;
            end
            default: e.bad = 1;
        endcase
        return e;
    endfunction

    // Writers in priority order: the youngest (EX) result is the architecturally newest one
    function automatic logic [31:0] operand(bit uses, logic [4:0] r, logic [31:0] fallback);
        bit          w_en [2];
        logic [4:0]  w_rd [2];
        logic [31:0] w_v  [2];
        if (!uses) return fallback;
        if (r == 0) return 32'h0;
        w_en = '{ex_wreg, mem_wreg}; w_rd = '{ex_wd, mem_wd}; w_v = '{ex_wdata, mem_wdata};
        for (int i = 0; i < 2; i++)
            if (w_en[i] && w_rd[i] == r) return w_v[i];
        return rf[r];
    endfunction

    task automatic set_inst(input mn_t mn, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [15:0] imm);
        cur_mn = mn; cur_rs = rs; cur_rt = rt; cur_rd = rd; cur_imm = imm;
        case (mn)
            M_ORI:  inst = {6'h0D, rs, rt, imm};
            M_ANDI: inst = {6'h0C, rs, rt, imm};
            M_XORI: inst = {6'h0E, rs, rt, imm};
            M_LUI:  inst = {6'h0F, rs, rt, imm};
            M_LW:   inst = {6'h23, rs, rt, imm};
            M_AND:  inst = {6'h00, rs, rt, rd, 5'h0, 6'h24};
            M_OR:   inst = {6'h00, rs, rt, rd, 5'h0, 6'h25};
            M_XOR:  inst = {6'h00, rs, rt, rd, 5'h0, 6'h26};
            M_NOR:  inst = {6'h00, rs, rt, rd, 5'h0, 6'h27};
            default: inst = imm[0] ? {6'h3F, rs, rt, imm} : {6'h00, rs, rt, rd, 5'h0, 6'h20};
        endcase
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".valid"},  bus.ex_valid_o, e_valid);
        chk({tag, ".aluop"},  bus.aluop_o, e_aluop);
        chk({tag, ".alusel"}, bus.alusel_o, e_alusel);
        chk({tag, ".reg1"},   bus.reg1_o, e_r1);
        chk({tag, ".reg2"},   bus.reg2_o, e_r2);
        chk({tag, ".wd"},     bus.wd_o, e_wd);
        chk({tag, ".wreg"},   bus.wreg_o, e_wreg);
        chk({tag, ".pc"},     bus.pc_o, e_pc);
        chk({tag, ".inv"},    bus.inst_invalid_o, e_bad);
    endtask

    task automatic clear_model();
        e_valid = 0; e_wreg = 0; e_bad = 0; e_aluop = '0; e_alusel = '0;
        e_r1 = '0; e_r2 = '0; e_pc = '0; e_wd = '0;
    endtask

    // One clock: check the combinational side, predict the edge, then check the register
    task automatic cycle(input string tag);
        exp_t e;
        bit   haz, ready_exp;
        #1;
        e   = expect_of(cur_mn, cur_rt, cur_rd, cur_imm);
        haz = ex_is_load && ex_wreg &&
              ((e.uses_rs && cur_rs != 0 && ex_wd == cur_rs) ||
               (e.uses_rt && cur_rt != 0 && ex_wd == cur_rt));
        ready_exp = flush || ((!e_valid || bus.ex_ready_i) && !haz);
        chk({tag, ".id_ready"}, id_ready, ready_exp);
        chk({tag, ".raddr1"}, r1_addr, cur_rs);
        chk({tag, ".raddr2"}, r2_addr, cur_rt);
        chk({tag, ".rden"}, {r1_rd, r2_rd}, {e.uses_rs, e.uses_rt});
        if (flush) e_valid = 0;
        else if (!e_valid || bus.ex_ready_i) begin
            if (if_valid && !haz) begin
                e_valid = 1; e_aluop = e.aluop; e_alusel = e.alusel; e_wd = e.dest;
                e_wreg = e.wr; e_bad = e.bad; e_pc = pc;
                e_r1 = operand(e.uses_rs, cur_rs, 32'h0);
                e_r2 = operand(e.uses_rt, cur_rt, e.imm_val);
            end else e_valid = 0;
        end
        @(posedge clk); #1;
        check_regs(tag);
    endtask

    initial begin
        rst = 1; if_valid = 0; flush = 0; pc = 0; inst = 0;
        ex_wreg = 0; ex_wd = 0; ex_wdata = 0; ex_is_load = 0;
        mem_wreg = 0; mem_wd = 0; mem_wdata = 0; bus.ex_ready_i = 0;
        foreach (rf[i]) rf[i] = $urandom;
        set_inst(M_BAD, 0, 0, 0, 16'h0);
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        check_regs("reset");
        chk("reset.id_ready", id_ready, 1'b0);
        rst = 0;

        // ORI $1,$0,0x1100
        bus.ex_ready_i = 1; if_valid = 1; pc = 32'h100;
        set_inst(M_ORI, 0, 1, 0, 16'h1100);
        cycle("ori");
        chk("ori.aluop_const", bus.aluop_o, 8'h25);
        chk("ori.reg2_const", bus.reg2_o, 32'h0000_1100);

        // OR $3,$1,$2 with both EX and MEM writing $1
        pc = 32'h104; set_inst(M_OR, 1, 2, 3, 16'h0);
        ex_wreg = 1; ex_wd = 1; ex_wdata = 32'hAAAA_0000;
        mem_wreg = 1; mem_wd = 1; mem_wdata = 32'h0000_5555;
        cycle("or_expri");
        chk("or_expri.reg1_const", bus.reg1_o, 32'hAAAA_0000);
        ex_wreg = 0; mem_wd = 2; pc = 32'h108;
        cycle("or_mem");
        chk("or_mem.reg2_const", bus.reg2_o, 32'h0000_5555);

        // load-use: LW in EX writing $4, ORI $5,$4,1 waits one cycle
        ex_is_load = 1; ex_wreg = 1; ex_wd = 4; ex_wdata = 32'hDEAD_BEEF; mem_wreg = 0;
        pc = 32'h10C; set_inst(M_ORI, 4, 5, 0, 16'h0001);
        cycle("lu_stall");
        chk("lu_stall.bubble", bus.ex_valid_o, 1'b0);
        ex_is_load = 0; ex_wreg = 0; mem_wreg = 1; mem_wd = 4; mem_wdata = 32'h0000_CAFE;
        cycle("lu_issue");
        chk("lu_issue.reg1_const", bus.reg1_o, 32'h0000_CAFE);

        // backpressure: hold LW for 3 cycles while XORI waits
        mem_wreg = 0; pc = 32'h110; set_inst(M_LW, 7, 6, 0, 16'hFFF8);
        cycle("bp_load");
        bus.ex_ready_i = 0; pc = 32'h114; set_inst(M_XORI, 2, 8, 0, 16'h00FF);
        for (int i = 0; i < 3; i++) cycle("bp_hold");
        chk("bp_hold.reg2_const", bus.reg2_o, 32'hFFFF_FFF8);
        bus.ex_ready_i = 1;
        cycle("bp_release");

        // flush beats hazard and backpressure
        bus.ex_ready_i = 0; flush = 1; ex_is_load = 1; ex_wreg = 1; ex_wd = 2;
        pc = 32'h118; set_inst(M_ORI, 2, 9, 0, 16'h0003);
        cycle("flush");
        chk("flush.valid_const", bus.ex_valid_o, 1'b0);
        flush = 0; ex_is_load = 0; ex_wreg = 0; bus.ex_ready_i = 1;
        pc = 32'h11C; set_inst(M_BAD, 3, 4, 5, 16'h0001);
        cycle("undef");
        chk("undef.inv_const", bus.inst_invalid_o, 1'b1);
        chk("undef.wreg_const", bus.wreg_o, 1'b0);

        // async reset while a valid op sits in ID/EX
        set_inst(M_ANDI, 1, 2, 0, 16'h1234); pc = 32'h120;
        cycle("pre_rst");
        rst = 1; #1;
        clear_model();
        check_regs("rst_async");
        chk("rst_async.id_ready", id_ready, 1'b0);
        @(posedge clk); #1;
        chk("rst_hold.id_ready", id_ready, 1'b0);
        chk("rst_hold.valid", bus.ex_valid_o, 1'b0);
        rst = 0;

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 15) == 0) rf[$urandom_range(0, 31)] = $urandom;
            if_valid = ($urandom_range(0, 9) < 8);
            flush = ($urandom_range(0, 9) == 0);
            bus.ex_ready_i = ($urandom_range(0, 9) < 7);
            ex_wreg = $urandom_range(0, 1); ex_wd = 5'($urandom_range(0, 7));
            ex_wdata = $urandom; ex_is_load = ($urandom_range(0, 9) < 3);
            mem_wreg = $urandom_range(0, 1); mem_wd = 5'($urandom_range(0, 7));
            mem_wdata = $urandom; pc = $urandom;
            set_inst(mn_t'($urandom_range(0, 9)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 16'($urandom));
            cycle("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_pipe_stage.md
Name: id_pipe_stage

Overview:
Registered MIPS instruction-decode stage.
- Decodes a 32-bit instruction into ALU op/select, write-back control and operands.
- Reads the register file and forwards results from EX and MEM.
- Detects load-use hazards and stalls upstream.
- Sits between the IF/ID register and EX. It drives the ID/EX pipeline register itself, with a valid/ready handshake, flush and a 1-cycle decode latency.

Parameters:
DATA_W, 32, datapath / register width
REG_AW, 5, register address width (32 GPRs, $0 hard-wired zero)
ALUOP_W, 8, ALU opcode width
ALUSEL_W, 3, ALU result-select width
FWD_EN, 1, 1 = EX/MEM forwarding enabled; 0 = operands taken from regfile only

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
if_valid_i  in  1  IF/ID holds a valid instruction
pc_i  in  DATA_W  instruction PC
inst_i  in  32  instruction word
id_ready_o  out  1  stage accepts pc_i/inst_i this cycle
flush_i  in  1  kill the instruction entering the ID/EX register
reg1_read_o / reg2_read_o  out  1  regfile read enables (combinational)
reg1_addr_o / reg2_addr_o  out  REG_AW  regfile read addresses = rs / rt (combinational)
reg1_data_i / reg2_data_i  in  DATA_W  regfile read data (same cycle)
ex_wreg_i, ex_wd_i, ex_wdata_i, ex_is_load_i  in  1/REG_AW/DATA_W/1  EX-stage writeback info
mem_wreg_i, mem_wd_i, mem_wdata_i  in  1/REG_AW/DATA_W  MEM-stage writeback info
ex_ready_i  in  1  EX accepts the ID/EX register contents
ex_valid_o  out  1  ID/EX register holds a valid op
aluop_o  out  ALUOP_W  ALU opcode
alusel_o  out  ALUSEL_W  result select
reg1_o / reg2_o  out  DATA_W  operands (reg2_o = immediate for I-type)
wd_o  out  REG_AW  destination register
wreg_o  out  1  write-back enable
pc_o  out  DATA_W  PC of the op
inst_invalid_o  out  1  op was an undefined instruction

Behaviour:
Reset (rst=1, async):
- All registered outputs are 0.
- id_ready_o=0 while rst=1.

Decode:
- Decode is combinational, then captured in the ID/EX register.
- Supported instructions:
  - ORI/ANDI/XORI: zero-extended imm; wd=rt; reads rs.
  - LUI: imm<<16; wd=rt; no reads.
  - SPECIAL AND/OR/XOR/NOR: wd=rd; reads rs and rt.
  - LW: sign-extended imm; wd=rt; reads rs.
- Any other opcode/funct: aluop=EXE_NOP_OP, wreg=0, inst_invalid_o=1.
- SPECIAL with rd=0 keeps wreg=1; the regfile ignores writes to $0.

Operand select, per port, when the port's read enable is 1:
- Address 0 → 0.
- Else if FWD_EN and ex_wreg_i and ex_wd_i == addr → ex_wdata_i.
- Else if FWD_EN and mem_wreg_i and mem_wd_i == addr → mem_wdata_i.
- Else → regN_data_i.
- EX has priority over MEM.
- A port with read enable 0 yields 0, or the immediate on port 2.

Load-use hazard:
- Condition: ex_is_load_i & ex_wreg_i & ex_wd_i≠0 & (port1 reads ex_wd_i or port2 reads ex_wd_i).
- With FWD_EN=0, any EX or MEM destination match with wreg=1 also stalls.

Handshake:
- advance = ~ex_valid_o | ex_ready_i.
- id_ready_o = advance & ~hazard.
- On advance:
  - ex_valid_o <= if_valid_i & ~hazard & ~flush_i.
  - Payload is loaded only when the new ex_valid_o=1. Otherwise only ex_valid_o clears (bubble).
- When not advancing, the ID/EX register holds all values stable; no payload change while ex_valid_o=1 & ~ex_ready_i.

Flush:
- flush_i has priority over everything.
- Next edge: ex_valid_o=0 regardless of ex_ready_i, and the entering instruction is dropped.
- id_ready_o=1 during flush unless rst.

Other rules:
- Latency: one edge from acceptance to ex_valid_o=1.
- Throughput: 1 instruction/cycle without hazards.
- Simultaneous hazard + flush: flush wins; a bubble is produced.
- A stall asserted by ex_is_load_i clears the cycle after EX advances.

Decomposition:
- Shared package/defines:
  - opcode and funct constants (EXE_ORI, EXE_ANDI, EXE_XORI, EXE_LUI, EXE_SPECIAL, EXE_LW, FUNCT_AND/OR/XOR/NOR)
  - ALU op codes (EXE_OR_OP, EXE_AND_OP, EXE_XOR_OP, EXE_NOR_OP, EXE_LUI_OP, EXE_LW_OP, EXE_NOP_OP)
  - ALU select codes (EXE_RES_LOGIC, EXE_RES_LOAD, EXE_RES_NOP)
  - ZeroWord and NOPRegAddr
- One sub-module, id_operand_mux: forwarding select plus hazard compare for one read port, instantiated twice.

Test Plan:
1. Reset mid-stream: assert rst with ex_valid_o=1 → all outputs 0 immediately (async); id_ready_o=0 until release.
2. ORI $1,$0,0x1100 with if_valid_i=1, ex_ready_i=1 → next cycle ex_valid_o=1, aluop=EXE_OR_OP, reg1_o=0, reg2_o=0x00001100, wd_o=1, wreg_o=1.
3. OR $3,$1,$2 with ex_wd_i=1/0xAAAA0000 and mem_wd_i=1/0x5555 and mem_wd_i... → reg1_o=0xAAAA0000 (EX priority). A repeat with only mem_wd_i=2/0x5555 gives reg2_o=0x5555.
4. Load-use: ex_is_load_i=1, ex_wd_i=4; ORI $5,$4,1 → id_ready_o=0 and bubble (ex_valid_o=0); when EX advances, the hazard clears and ORI issues next cycle.
5. Backpressure: ex_ready_i=0 for 3 cycles with valid op → outputs held bit-stable, id_ready_o=0; ex_ready_i=1 → next op loads.
6. Flush with hazard and ex_ready_i=0 → next edge ex_valid_o=0. An undefined opcode 0x3F then gives inst_invalid_o=1, wreg_o=0.
